dnn_mem_fix: RTL

- Weight/activation store and memory responder for the fixed-point DNN inference engine. It answers the engine's mem_addr requests with signed mem_data.
- A streaming load port with a valid/ready handshake lets a host fill the image and weight regions before inference starts.
- One write port (loader) and one read port (engine) give 1W1R. This is the slave side of the engine's memory-read interface.

---
 rtl/dnn_mem_fix.sv | 107 ++++++++++
 1 files changed

// File: rtl/dnn_mem_fix.sv
// dnn_mem_fix: signed weight/activation store for the fixed-point DNN engine.
// 1W1R: a streaming loader fills the array, the engine reads with 1-cycle latency.
module dnn_mem_fix #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 16384
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data,
  input  logic                         load_start,
  input  logic [ADDR_WIDTH-1:0]        load_base,
  input  logic [ADDR_WIDTH-1:0]        load_len,
  input  logic                         ld_valid,
  input  logic signed [DATA_WIDTH-1:0] ld_data,
  output logic                         ld_ready,
  output logic                         load_busy,
  output logic                         load_done,
  output logic                         load_err,
  output logic signed [15:0]           load_sum
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, state_n;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]         wr_ptr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  beat;
  logic                  last_beat;
  logic                  start_ok;
  logic                  start_bad;

  // Range check in one extra bit so base+len cannot wrap.
  assign end_addr  = {1'b0, load_base} + {1'b0, load_len};
  assign start_bad = (state == IDLE) && load_start && (end_addr > LIMIT);
  assign start_ok  = (state == IDLE) && load_start && !(end_addr > LIMIT);

  assign ld_ready  = (state == LOAD);
  assign load_busy = (state == LOAD);
  assign load_done = (state == DONE);
  assign beat      = ld_valid && ld_ready;
  assign last_beat = beat && (remaining == ADDR_WIDTH'(1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_n = (load_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (last_beat) begin
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      load_sum  <= '0;
      load_err  <= 1'b0;
      mem_data  <= '0;
    end else begin
      state    <= state_n;
      load_err <= start_bad;
      if ({1'b0, mem_addr} < LIMIT) begin
        mem_data <= mem[mem_addr[IW-1:0]];
      end else begin
        mem_data <= '0;
      end
      if ((state == IDLE) && load_start) begin
        load_sum <= '0;
      end
      if (start_ok) begin
        wr_ptr    <= load_base[IW-1:0];
        remaining <= load_len;
      end
      if (beat) begin
        wr_ptr    <= wr_ptr + IW'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
        load_sum  <= load_sum + 16'(ld_data);
      end
    end
  end

  // Storage is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wr_ptr] <= ld_data;
    end
  end

endmodule
